// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the MEM stage: funct3 values, exception causes, FSM states.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StRmwWr = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } access_size_e;

    // Unknown encodings fall back to a full-word access.
    function automatic access_size_e f3_size(input logic [2:0] f3);
        access_size_e sz;
        case (f3)
            F3_B, F3_BU: sz = SzByte;
            F3_H, F3_HU: sz = SzHalf;
            default:     sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM request, data-RAM port and MEM/WB result bundle of the MEM stage.
interface mem_access_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_res;
    logic        in_reg_write;

    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_waddr;
    logic [31:0] ram_raddr;
    logic [31:0] ram_rdata;

    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;

    // Environment side: drives requests and RAM read data.
    modport master (
        output in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
               in_alu_res, in_reg_write, ram_rdata,
        input  in_ready, ram_wdata, ram_we, ram_re, ram_waddr, ram_raddr,
               wb_valid, wb_reg_write, wb_rd, wb_data, exc_valid, exc_cause
    );

    // Stage side.
    modport slave (
        input  in_valid, in_load, in_store, in_funct3, in_addr, in_wdata, in_rd,
               in_alu_res, in_reg_write, ram_rdata,
        output in_ready, ram_wdata, ram_we, ram_re, ram_waddr, ram_raddr,
               wb_valid, wb_reg_write, wb_rd, wb_data, exc_valid, exc_cause
    );

endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane logic: load extract/extend, sub-word store merge, misalignment detect.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged,
    output logic        misaligned
);

    access_size_e size;
    logic         uns;
    logic [4:0]   sh;
    logic [31:0]  shifted;

    always_comb begin
        size       = f3_size(funct3);
        uns        = f3_unsigned(funct3);
        sh         = {byte_off, 3'b000};
        shifted    = rdata >> sh;
        load_data  = rdata;
        merged     = wdata;
        misaligned = 1'b0;
        unique case (size)
            SzByte: begin
                load_data = uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
                merged    = (rdata & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
            end
            SzHalf: begin
                misaligned = byte_off[0];
                load_data  = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
                merged     = (rdata & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata[15:0]} << sh);
            end
            default: begin
                misaligned = |byte_off;
                load_data  = rdata;
                merged     = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: word-RAM access with read-modify-write for SB/SH and a registered WB bundle.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 2046
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_stage_if.slave bus
);

    state_e      state_q, state_d;
    logic [29:0] rmw_widx_q, rmw_widx_d;
    logic [31:0] rmw_word_q, rmw_word_d;

    logic        wb_valid_q, wb_valid_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [3:0]  exc_cause_q, exc_cause_d;

    logic [29:0] widx;
    logic        is_load, is_store, accept, fault, bad, sub_word;
    logic        misaligned;
    logic [31:0] load_data, merged;
    logic        ram_we_c, ram_re_c;

    assign widx     = bus.in_addr[31:2];
    assign is_load  = bus.in_load;
    assign is_store = bus.in_store & ~bus.in_load;
    assign accept   = bus.in_valid && (state_q == StIdle);
    assign fault    = {2'b00, widx} >= 32'(MEM_WORDS);
    assign bad      = misaligned | fault;
    assign sub_word = f3_size(bus.in_funct3) != SzWord;

    mem_lane_align u_lane_align (
        .funct3     (bus.in_funct3),
        .byte_off   (bus.in_addr[1:0]),
        .rdata      (bus.ram_rdata),
        .wdata      (bus.in_wdata),
        .load_data  (load_data),
        .merged     (merged),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d        = state_q;
        rmw_widx_d     = rmw_widx_q;
        rmw_word_d     = rmw_word_q;
        ram_we_c       = 1'b0;
        ram_re_c       = 1'b0;
        bus.ram_waddr  = {2'b00, widx};
        bus.ram_raddr  = {2'b00, widx};
        bus.ram_wdata  = bus.in_wdata;
        wb_valid_d     = 1'b0;
        wb_reg_write_d = wb_reg_write_q;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        exc_valid_d    = 1'b0;
        exc_cause_d    = exc_cause_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if ((is_load || is_store) && bad) begin
                        // Misalignment takes precedence over an out-of-range fault.
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = bus.in_rd;
                        exc_valid_d    = 1'b1;
                        if (is_load) begin
                            exc_cause_d = misaligned ? EXC_LOAD_MISALIGNED : EXC_LOAD_FAULT;
                        end else begin
                            exc_cause_d = misaligned ? EXC_STORE_MISALIGNED : EXC_STORE_FAULT;
                        end
                    end else if (is_load) begin
                        ram_re_c       = 1'b1;
                        wb_valid_d     = 1'b1;
                        wb_data_d      = load_data;
                        wb_rd_d        = bus.in_rd;
                        wb_reg_write_d = bus.in_rd != 5'd0;
                    end else if (is_store && !sub_word) begin
                        ram_we_c       = 1'b1;
                        wb_valid_d     = 1'b1;
                        wb_reg_write_d = 1'b0;
                        wb_rd_d        = bus.in_rd;
                    end else if (is_store) begin
                        // Read phase of RMW; the write lands in StRmwWr.
                        ram_re_c   = 1'b1;
                        rmw_word_d = merged;
                        rmw_widx_d = widx;
                        state_d    = StRmwWr;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = bus.in_alu_res;
                        wb_rd_d        = bus.in_rd;
                        wb_reg_write_d = bus.in_reg_write;
                    end
                end
            end
            StRmwWr: begin
                ram_we_c       = 1'b1;
                bus.ram_waddr  = {2'b00, rmw_widx_q};
                bus.ram_wdata  = rmw_word_q;
                wb_valid_d     = 1'b1;
                wb_reg_write_d = 1'b0;
                state_d        = StIdle;
            end
        endcase
    end

    // RAM strobes are gated by reset so a pending RMW write never reaches the RAM.
    assign bus.ram_we       = rst_n & ram_we_c;
    assign bus.ram_re       = rst_n & ram_re_c;
    assign bus.in_ready     = state_q == StIdle;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_reg_write = wb_reg_write_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.exc_valid    = exc_valid_q;
    assign bus.exc_cause    = exc_cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            rmw_widx_q     <= '0;
            rmw_word_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            exc_valid_q    <= 1'b0;
            exc_cause_q    <= '0;
        end else begin
            state_q        <= state_d;
            rmw_widx_q     <= rmw_widx_d;
            rmw_word_q     <= rmw_word_d;
            wb_valid_q     <= wb_valid_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            exc_valid_q    <= exc_valid_d;
            exc_cause_q    <= exc_cause_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a word-RAM model and hand-computed expectations.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int unsigned MemWords = 2046;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clear_mem = 1'b1;
    int   errors = 0;
    int   checks = 0;

    mem_access_stage_if bus ();

    mem_access_stage #(
        .MEM_WORDS (MemWords)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MemWords];

    assign bus.ram_rdata = (bus.ram_raddr < MemWords) ? mem[bus.ram_raddr[10:0]] : 32'h0;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < int'(MemWords); i++) mem[i] <= 32'h0;
        end else if (bus.ram_we && bus.ram_waddr < MemWords) begin
            mem[bus.ram_waddr[10:0]] <= bus.ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request just after the falling edge, then settle.
    task automatic req(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] alu, input logic rw);
        @(negedge clk);
        bus.in_valid     = 1'b1;
        bus.in_load      = ld;
        bus.in_store     = st;
        bus.in_funct3    = f3;
        bus.in_addr      = a;
        bus.in_wdata     = wd;
        bus.in_rd        = rd;
        bus.in_alu_res   = alu;
        bus.in_reg_write = rw;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_load      = 1'b0;
        bus.in_store     = 1'b0;
        bus.in_funct3    = 3'b000;
        bus.in_addr      = 32'h0;
        bus.in_wdata     = 32'h0;
        bus.in_rd        = 5'd0;
        bus.in_alu_res   = 32'h0;
        bus.in_reg_write = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("rst_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
        check("rst_wb_data", bus.wb_data, 32'h0);
        check("rst_wb_rd", {27'h0, bus.wb_rd}, 32'h0);
        check("rst_exc", {27'h0, bus.exc_valid, bus.exc_cause}, 32'h0);
        check("rst_ram_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'h0);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        @(negedge clk);
        clear_mem = 1'b0;
        rst_n = 1'b1;

        // SW 0x10 then LW 0x10
        req(1'b0, 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 5'd0, 32'h0, 1'b0);
        check("sw_we", {31'h0, bus.ram_we}, 32'h1);
        check("sw_re", {31'h0, bus.ram_re}, 32'h0);
        check("sw_waddr", bus.ram_waddr, 32'd4);
        check("sw_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        tick();
        check("sw_wb", {29'h0, bus.wb_valid, bus.wb_reg_write, bus.exc_valid}, 32'b100);
        req(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 5'd5, 32'h0, 1'b0);
        check("lw_re", {30'h0, bus.ram_we, bus.ram_re}, 32'b01);
        check("lw_raddr", bus.ram_raddr, 32'd4);
        tick();
        check("lw_data", bus.wb_data, 32'hDEAD_BEEF);
        check("lw_wb", {29'h0, bus.wb_valid, bus.wb_reg_write, bus.exc_valid}, 32'b110);
        check("lw_rd", {27'h0, bus.wb_rd}, 32'd5);
        idle();
        tick();
        check("idle_valid", {31'h0, bus.wb_valid}, 32'h0);
        check("idle_hold_data", bus.wb_data, 32'hDEAD_BEEF);

        // SB 0x11 via read-modify-write
        req(1'b0, 1'b1, F3_B, 32'h11, 32'h0000_0055, 5'd0, 32'h0, 1'b0);
        check("sb_c0_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'b01);
        check("sb_c0_ready", {31'h0, bus.in_ready}, 32'h1);
        tick();
        check("sb_c0_wb_valid", {31'h0, bus.wb_valid}, 32'h0);
        check("sb_rmw_ready", {31'h0, bus.in_ready}, 32'h0);
        check("sb_rmw_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'b10);
        check("sb_rmw_waddr", bus.ram_waddr, 32'd4);
        check("sb_rmw_wdata", bus.ram_wdata, 32'hDEAD_55EF);
        req(1'b1, 1'b0, F3_W, 32'h20, 32'h0, 5'd9, 32'h0, 1'b0);
        check("rmw_ignores_in", {30'h0, bus.ram_re, bus.in_ready}, 32'b00);
        tick();
        check("sb_wb", {29'h0, bus.wb_valid, bus.wb_reg_write, bus.in_ready}, 32'b101);
        check("sb_mem", mem[4], 32'hDEAD_55EF);
        req(1'b1, 1'b0, F3_BU, 32'h11, 32'h0, 5'd7, 32'h0, 1'b0);
        tick();
        check("lbu_after_sb", bus.wb_data, 32'h0000_0055);

        // Sign/zero extension on word 4 = 0x80FF7F01
        req(1'b0, 1'b1, F3_W, 32'h10, 32'h80FF_7F01, 5'd0, 32'h0, 1'b0);
        tick();
        req(1'b1, 1'b0, F3_B, 32'h13, 32'h0, 5'd1, 32'h0, 1'b0);
        tick();
        check("lb_13", bus.wb_data, 32'hFFFF_FF80);
        req(1'b1, 1'b0, F3_BU, 32'h13, 32'h0, 5'd1, 32'h0, 1'b0);
        tick();
        check("lbu_13", bus.wb_data, 32'h0000_0080);
        req(1'b1, 1'b0, F3_H, 32'h12, 32'h0, 5'd1, 32'h0, 1'b0);
        tick();
        check("lh_12", bus.wb_data, 32'hFFFF_80FF);
        req(1'b1, 1'b0, F3_HU, 32'h10, 32'h0, 5'd0, 32'h0, 1'b0);
        tick();
        check("lhu_10", bus.wb_data, 32'h0000_7F01);
        check("lhu_rd0_no_write", {31'h0, bus.wb_reg_write}, 32'h0);

        // Misaligned accesses
        req(1'b1, 1'b0, F3_W, 32'h12, 32'h0, 5'd2, 32'h0, 1'b0);
        check("lw_mis_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'b00);
        tick();
        check("lw_mis_exc", {27'h0, bus.exc_valid, bus.exc_cause}, {27'h0, 1'b1, 4'd4});
        check("lw_mis_wb", {30'h0, bus.wb_valid, bus.wb_reg_write}, 32'b10);
        req(1'b0, 1'b1, F3_H, 32'h13, 32'h1234, 5'd0, 32'h0, 1'b0);
        check("sh_mis_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'b00);
        tick();
        check("sh_mis_exc", {27'h0, bus.exc_valid, bus.exc_cause}, {27'h0, 1'b1, 4'd6});
        check("sh_mis_ready", {31'h0, bus.in_ready}, 32'h1);

        // Range boundary: last valid word, then first faulting word
        req(1'b1, 1'b0, F3_W, 32'd8180, 32'h0, 5'd3, 32'h0, 1'b0);
        check("lw_last_re", {31'h0, bus.ram_re}, 32'h1);
        tick();
        check("lw_last_exc", {31'h0, bus.exc_valid}, 32'h0);
        check("lw_last_data", bus.wb_data, 32'h0);
        req(1'b0, 1'b1, F3_W, 32'd8184, 32'hCAFE_F00D, 5'd0, 32'h0, 1'b0);
        check("sw_fault_we", {31'h0, bus.ram_we}, 32'h0);
        tick();
        check("sw_fault_exc", {27'h0, bus.exc_valid, bus.exc_cause}, {27'h0, 1'b1, 4'd7});
        req(1'b1, 1'b0, F3_W, 32'd8184, 32'h0, 5'd3, 32'h0, 1'b0);
        check("lw_fault_re", {31'h0, bus.ram_re}, 32'h0);
        tick();
        check("lw_fault_exc", {27'h0, bus.exc_valid, bus.exc_cause}, {27'h0, 1'b1, 4'd5});

        // Non-memory op, unknown funct3 load, load+store treated as load
        req(1'b0, 1'b0, F3_W, 32'h10, 32'h0, 5'd3, 32'h1234_5678, 1'b1);
        check("alu_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'b00);
        tick();
        check("alu_data", bus.wb_data, 32'h1234_5678);
        check("alu_wb", {28'h0, bus.wb_valid, bus.wb_reg_write, bus.exc_valid, 1'b0}, 32'b1100);
        check("alu_rd", {27'h0, bus.wb_rd}, 32'd3);
        req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 5'd4, 32'h0, 1'b0);
        tick();
        check("f3_unknown_as_w", bus.wb_data, 32'h80FF_7F01);
        req(1'b1, 1'b1, F3_W, 32'h10, 32'h1111_1111, 5'd4, 32'h0, 1'b0);
        check("ld_st_is_load", {30'h0, bus.ram_we, bus.ram_re}, 32'b01);
        tick();
        check("ld_st_data", bus.wb_data, 32'h80FF_7F01);

        // Reset in the middle of an SH read-modify-write
        req(1'b0, 1'b1, F3_H, 32'h10, 32'h0000_AAAA, 5'd0, 32'h0, 1'b0);
        tick();
        check("sh_rmw_pending", {31'h0, bus.ram_we}, 32'h1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid_strobes", {30'h0, bus.ram_we, bus.ram_re}, 32'b00);
        check("rst_mid_wb", {26'h0, bus.wb_valid, bus.wb_reg_write, bus.exc_valid, bus.in_ready,
                             2'b00}, 32'b000100);
        check("rst_mid_data", bus.wb_data, 32'h0);
        check("rst_mid_cause", {28'h0, bus.exc_cause}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_mid_mem", mem[4], 32'h80FF_7F01);
        req(1'b1, 1'b0, F3_W, 32'h10, 32'h0, 5'd6, 32'h0, 1'b0);
        tick();
        check("rst_mid_reload", bus.wb_data, 32'h80FF_7F01);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
